// File: rtl/bc_horner.sv
// rtl/bc_horner.sv - Moore control FSM sequencing Horner evaluation S = ((a*x)+b)*x + c
module bc_horner #(
   parameter logic H_SOMA = 1'b0,
   parameter logic H_MULT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [1:0] m0,
   output logic [1:0] m1,
   output logic [1:0] m2,
   output logic       lx,
   output logic       ls,
   output logic       lh,
   output logic       h,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDX  = 3'd1,
      MULA = 3'd2,
      SOMB = 3'd3,
      MULX = 3'd4,
      SOMC = 3'd5,
      FIM  = 3'd6
   } state_t;

   state_t state_q;
   state_t state_d;

   // State register; rst drops straight to IDLE without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing; start only matters in IDLE, every other state advances unconditionally.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = start ? LDX : IDLE;
         LDX:     state_d = MULA;
         MULA:    state_d = SOMB;
         SOMB:    state_d = MULX;
         MULX:    state_d = SOMC;
         SOMC:    state_d = FIM;
         FIM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath controls decoded from state alone, so reset forces every output to 0.
   always_comb begin
      m0   = 2'd0;
      m1   = 2'd0;
      m2   = 2'd0;
      lx   = 1'b0;
      ls   = 1'b0;
      lh   = 1'b0;
      h    = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         LDX: begin
            // X <= x
            lx   = 1'b1;
            busy = 1'b1;
         end
         MULA: begin
            // H <= a * X
            m0   = 2'd1;
            m1   = 2'd1;
            m2   = 2'd1;
            h    = H_MULT;
            lh   = 1'b1;
            busy = 1'b1;
         end
         SOMB: begin
            // H <= H + b
            m0   = 2'd2;
            m1   = 2'd0;
            m2   = 2'd3;
            h    = H_SOMA;
            lh   = 1'b1;
            busy = 1'b1;
         end
         MULX: begin
            // H <= H * X
            m1   = 2'd1;
            m2   = 2'd3;
            h    = H_MULT;
            lh   = 1'b1;
            busy = 1'b1;
         end
         SOMC: begin
            // S <= H + c; the only state that touches the result register
            m0   = 2'd3;
            m1   = 2'd0;
            m2   = 2'd3;
            h    = H_SOMA;
            ls   = 1'b1;
            busy = 1'b1;
         end
         FIM: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bc_horner.sv
// tb/tb_bc_horner.sv - directed bench for bc_horner with a behavioural 16-bit datapath
module tb_bc_horner;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] m0, m1, m2;
   logic       lx, ls, lh, h, busy, done;

   logic [15:0] a, b, c, x;
   logic [15:0] x_r = 16'd0;
   logic [15:0] s_r = 16'd0;
   logic [15:0] h_r = 16'd0;
   logic [15:0] mu0, opa, opb, ula;

   int vectors = 0;
   int miscompares = 0;

   wire [11:0] outs = {m0, m1, m2, lx, ls, lh, h, busy, done};

   // Expected {m0,m1,m2,lx,ls,lh,h,busy,done} for LDX..FIM, then IDLE
   logic [11:0] exp_tab [0:6];

   bc_horner #(.H_SOMA(1'b0), .H_MULT(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .m0    (m0),
      .m1    (m1),
      .m2    (m2),
      .lx    (lx),
      .ls    (ls),
      .lh    (lh),
      .h     (h),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Datapath model: muxes and ula as described by the control encoding
   always_comb begin
      mu0 = 16'd0;
      opa = 16'd0;
      opb = 16'd0;
      case (m0)
         2'd0: mu0 = 16'd0;
         2'd1: mu0 = a;
         2'd2: mu0 = b;
         default: mu0 = c;
      endcase
      case (m1)
         2'd0: opb = mu0;
         2'd1: opb = x_r;
         2'd2: opb = s_r;
         default: opb = h_r;
      endcase
      case (m2)
         2'd0: opa = x_r;
         2'd1: opa = mu0;
         2'd2: opa = s_r;
         default: opa = h_r;
      endcase
      ula = h ? (opa * opb) : (opa + opb);
   end

   // Datapath registers; never reset, so an abort leaves them as they were
   always_ff @(posedge clk) begin
      if (lx) x_r <= x;
      if (ls) s_r <= ula;
      if (lh) h_r <= ula;
   end

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (outs !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_outs: got %b want %b", outs, 12'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (outs !== 12'd0) begin
            miscompares++;
            $display("FAIL idle_outs cycle %0d: got %b want %b", i, outs, 12'd0);
         end
      end
   endtask

   task automatic test_basic();
      int cyc;
      a = 16'd2; b = 16'd3; c = 16'd4; x = 16'd5;
      start_pulse();
      wait_done(cyc);
      vectors++;
      if (cyc !== 6) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d want %0d", cyc, 6);
      end
      vectors++;
      if (s_r !== 16'd69) begin
         miscompares++;
         $display("FAIL basic_result: got %0d want %0d", s_r, 69);
      end
      @(posedge clk); #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL basic_after: busy,done got %b want %b", {busy, done}, 2'b00);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      a = 16'd1; b = 16'd0; c = 16'd0; x = 16'd256;
      start_pulse();
      wait_done(cyc);
      vectors++;
      if (cyc !== 6 || s_r !== 16'd0) begin
         miscompares++;
         $display("FAIL wrap_x256: got lat %0d res %0d want lat 6 res 0", cyc, s_r);
      end
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'd0; c = 16'd1; x = 16'd1;
      start_pulse();
      wait_done(cyc);
      vectors++;
      if (cyc !== 6 || s_r !== 16'd0) begin
         miscompares++;
         $display("FAIL wrap_ffff: got lat %0d res %0d want lat 6 res 0", cyc, s_r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int ndone;
      int last;
      ndone = 0;
      last = -1;
      a = 16'd1; b = 16'd1; c = 16'd1; x = 16'd2;
      start = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            vectors++;
            if (s_r !== 16'd7) begin
               miscompares++;
               $display("FAIL held_result at cycle %0d: got %0d want %0d", i, s_r, 7);
            end
            if (last >= 0) begin
               vectors++;
               if (i - last !== 7) begin
                  miscompares++;
                  $display("FAIL held_period: got %0d want %0d", i - last, 7);
               end
            end
            last = i;
         end
      end
      start = 1'b0;
      vectors++;
      if (ndone !== 4) begin
         miscompares++;
         $display("FAIL held_count: got %0d want %0d", ndone, 4);
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int cyc;
      int ndone;
      ndone = 0;
      a = 16'd3; b = 16'd0; c = 16'd0; x = 16'd3;
      start_pulse();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (outs !== exp_tab[3]) begin
         miscompares++;
         $display("FAIL abort_in_mulx: got %b want %b", outs, exp_tab[3]);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (outs !== 12'd0) begin
         miscompares++;
         $display("FAIL abort_async_outs: got %b want %b", outs, 12'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      vectors++;
      if (ndone !== 0 || s_r !== 16'd7) begin
         miscompares++;
         $display("FAIL abort_no_done: got dones %0d S %0d want dones 0 S 7", ndone, s_r);
      end
      start_pulse();
      wait_done(cyc);
      vectors++;
      if (cyc !== 6 || s_r !== 16'd27) begin
         miscompares++;
         $display("FAIL abort_restart: got lat %0d res %0d want lat 6 res 27", cyc, s_r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_state_table();
      int ndone;
      ndone = 0;
      a = 16'd1; b = 16'd2; c = 16'd3; x = 16'd10;
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
         vectors++;
         if (outs !== exp_tab[i]) begin
            miscompares++;
            $display("FAIL table_state %0d: got %b want %b", i, outs, exp_tab[i]);
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (outs !== exp_tab[6]) begin
         miscompares++;
         $display("FAIL table_idle: got %b want %b", outs, exp_tab[6]);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      vectors++;
      if (ndone !== 1) begin
         miscompares++;
         $display("FAIL ignore_start_dones: got %0d want %0d", ndone, 1);
      end
      vectors++;
      if (s_r !== 16'd123) begin
         miscompares++;
         $display("FAIL table_result: got %0d want %0d", s_r, 123);
      end
   endtask

   initial begin
      exp_tab[0] = 12'b00_00_00_1_0_0_0_1_0;
      exp_tab[1] = 12'b01_01_01_0_0_1_1_1_0;
      exp_tab[2] = 12'b10_00_11_0_0_1_0_1_0;
      exp_tab[3] = 12'b00_01_11_0_0_1_1_1_0;
      exp_tab[4] = 12'b11_00_11_0_1_0_0_1_0;
      exp_tab[5] = 12'b00_00_00_0_0_0_0_1_1;
      exp_tab[6] = 12'b00_00_00_0_0_0_0_0_0;
      a = 16'd0; b = 16'd0; c = 16'd0; x = 16'd0;
      rst = 1'b1;
      start = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_abort();
      test_state_table();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
